// File: rtl/seg_pkg.sv
// Shared segment-register definitions: select encoding, requester indices and
// the round-robin pointer type used by the segment write arbiter.
package seg_pkg;

    localparam int SEG_NUM = 6;

    typedef logic [2:0]  seg_sel_t;
    typedef logic [15:0] seg_data_t;

    localparam seg_sel_t SEG_ES = 3'd0;
    localparam seg_sel_t SEG_CS = 3'd1;
    localparam seg_sel_t SEG_SS = 3'd2;
    localparam seg_sel_t SEG_DS = 3'd3;
    localparam seg_sel_t SEG_FS = 3'd4;
    localparam seg_sel_t SEG_GS = 3'd5;

    localparam int REQ_WB  = 0;
    localparam int REQ_FAR = 1;
    localparam int REQ_EXC = 2;

    // Round-robin position over the two rotating requesters (writeback, far).
    typedef enum logic {
        RR_WB  = 1'b0,
        RR_FAR = 1'b1
    } rr_ptr_e;

    function automatic logic seg_legal(input seg_sel_t sel);
        return sel < 3'(SEG_NUM);
    endfunction

endpackage

// File: rtl/segment_write_arbiter_if.sv
// Request, reservation and register-file write-port bundle of the segment
// write arbiter; the slave modport is the arbiter side.
interface segment_write_arbiter_if
    import seg_pkg::*;
#(
    parameter int NREQ = 3
);

    logic      [NREQ-1:0]    req_valid;
    seg_sel_t  [NREQ-1:0]    req_sel;
    seg_data_t [NREQ-1:0]    req_data;
    logic      [NREQ-1:0]    req_ready;

    logic                    rsv_valid;
    seg_sel_t                rsv_sel;
    logic                    rsv_ready;

    logic                    flush;

    seg_sel_t                write_select;
    seg_data_t               write_data;
    logic                    write_enable;

    logic      [SEG_NUM-1:0] seg_busy;
    logic                    sel_err;

    modport master (
        output req_valid, req_sel, req_data, rsv_valid, rsv_sel, flush,
        input  req_ready, rsv_ready, write_select, write_data, write_enable,
               seg_busy, sel_err
    );

    modport slave (
        input  req_valid, req_sel, req_data, rsv_valid, rsv_sel, flush,
        output req_ready, rsv_ready, write_select, write_data, write_enable,
               seg_busy, sel_err
    );

endinterface

// File: rtl/seg_pending_counter.sv
// Saturating up/down count of writes still in flight to one segment, with a
// registered nonzero flag taken after the update.
module seg_pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    logic [CNT_W-1:0] count_next;

    // Simultaneous inc and dec cancel; clear wins over both.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (inc && !dec) begin
            if (count != '1) begin
                count_next = count + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count_next = count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            count <= count_next;
            busy  <= (count_next != '0);
        end
    end

endmodule

// File: rtl/segment_write_arbiter.sv
// Shares the segment register file write port among writeback, far transfer
// and exception requesters, and tracks pending writes per segment for decode.
module segment_write_arbiter
    import seg_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CNT_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    segment_write_arbiter_if.slave  bus
);

    rr_ptr_e          rr_ptr;
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic             grant_any;
    seg_sel_t         gnt_sel;
    seg_data_t        gnt_data;
    logic             gnt_legal;

    logic             wb_dec;
    logic             dec_same;
    logic             rsv_full;
    logic             rsv_ok;
    logic             rsv_take;

    logic [CNT_W-1:0] cnt [SEG_NUM];
    logic [SEG_NUM-1:0] busy;

    // Exception preempts the rotation; flush only squashes writeback.
    always_comb begin
        eligible          = bus.req_valid;
        eligible[REQ_WB]  = bus.req_valid[REQ_WB] && !bus.flush;
        grant             = '0;
        if (!reset) begin
            if (eligible[REQ_EXC]) begin
                grant[REQ_EXC] = 1'b1;
            end else if (rr_ptr == RR_WB) begin
                if (eligible[REQ_WB]) begin
                    grant[REQ_WB] = 1'b1;
                end else if (eligible[REQ_FAR]) begin
                    grant[REQ_FAR] = 1'b1;
                end
            end else begin
                if (eligible[REQ_FAR]) begin
                    grant[REQ_FAR] = 1'b1;
                end else if (eligible[REQ_WB]) begin
                    grant[REQ_WB] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_sel  = '0;
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_sel  = bus.req_sel[i];
                gnt_data = bus.req_data[i];
            end
        end
    end

    assign grant_any     = |grant;
    assign gnt_legal     = seg_legal(gnt_sel);
    assign bus.req_ready = grant;

    assign wb_dec   = grant[REQ_WB] && seg_legal(bus.req_sel[REQ_WB]);
    assign dec_same = wb_dec && (bus.req_sel[REQ_WB] == bus.rsv_sel);

    always_comb begin
        rsv_full = 1'b0;
        for (int n = 0; n < SEG_NUM; n++) begin
            if (bus.rsv_sel == 3'(n)) begin
                rsv_full = (cnt[n] == '1);
            end
        end
    end

    // A full segment can still accept a reservation when it drains this cycle.
    assign rsv_ok        = !reset && !bus.flush && seg_legal(bus.rsv_sel) &&
                           (!rsv_full || dec_same);
    assign bus.rsv_ready = rsv_ok;
    assign rsv_take      = bus.rsv_valid && rsv_ok;

    for (genvar n = 0; n < SEG_NUM; n++) begin : g_cnt
        seg_pending_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (rsv_take && (bus.rsv_sel == 3'(n))),
            .dec   (wb_dec && (bus.req_sel[REQ_WB] == 3'(n))),
            .clear (bus.flush),
            .count (cnt[n]),
            .busy  (busy[n])
        );
    end

    assign bus.seg_busy = busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= RR_WB;
        end else if (grant[REQ_WB]) begin
            rr_ptr <= RR_FAR;
        end else if (grant[REQ_FAR]) begin
            rr_ptr <= RR_WB;
        end
    end

    // Illegal selects are consumed but only raise sel_err, never a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.write_enable <= 1'b0;
            bus.write_select <= '0;
            bus.write_data   <= '0;
            bus.sel_err      <= 1'b0;
        end else begin
            bus.write_enable <= grant_any && gnt_legal;
            bus.sel_err      <= grant_any && !gnt_legal;
            if (grant_any && gnt_legal) begin
                bus.write_select <= gnt_sel;
                bus.write_data   <= gnt_data;
            end
        end
    end

endmodule

// File: tb/tb_segment_write_arbiter.sv
// Directed self-checking bench for segment_write_arbiter: arbitration,
// scoreboard, flush, illegal select and reset behaviour.
module tb_segment_write_arbiter;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [2:0]  c_valid [5] = '{3'b011, 3'b011, 3'b111, 3'b011, 3'b011};
    logic [2:0]  c_ready [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [2:0]  c_sel   [5] = '{3'd0, 3'd5, 3'd4, 3'd0, 3'd5};
    logic [15:0] c_data  [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h1111, 16'h2222};

    segment_write_arbiter_if bus ();

    segment_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] valid,
                                 input logic [2:0] s0, input logic [15:0] d0,
                                 input logic [2:0] s1, input logic [15:0] d1,
                                 input logic [2:0] s2, input logic [15:0] d2);
        bus.req_valid   = valid;
        bus.req_sel[0]  = s0;
        bus.req_data[0] = d0;
        bus.req_sel[1]  = s1;
        bus.req_data[1] = d1;
        bus.req_sel[2]  = s2;
        bus.req_data[2] = d2;
    endtask

    task automatic idle();
        applyStimulus(3'b000, 3'd0, 16'h0, 3'd0, 16'h0, 3'd0, 16'h0);
        bus.rsv_valid = 1'b0;
        bus.rsv_sel   = 3'd0;
        bus.flush     = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle();

        // Handshakes are refused while reset is held.
        nextCycle();
        nextCycle();
        bus.req_valid = 3'b111;
        bus.rsv_valid = 1'b1;
        bus.rsv_sel   = 3'd3;
        #1;
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst_rsv_ready", 32'(bus.rsv_ready), 32'h0);
        nextCycle();
        reset = 1'b0;
        idle();
        checkOutput("rst_we",   32'(bus.write_enable), 32'h0);
        checkOutput("rst_ws",   32'(bus.write_select), 32'h0);
        checkOutput("rst_wd",   32'(bus.write_data),   32'h0);
        checkOutput("rst_err",  32'(bus.sel_err),      32'h0);
        checkOutput("rst_busy", 32'(bus.seg_busy),     32'h0);

        // Single writeback request to CS.
        applyStimulus(3'b001, 3'd1, 16'hA123, 3'd0, 16'h0, 3'd0, 16'h0);
        #1;
        checkOutput("single_ready", 32'(bus.req_ready), 32'h1);
        nextCycle();
        idle();
        checkOutput("single_we",  32'(bus.write_enable), 32'h1);
        checkOutput("single_ws",  32'(bus.write_select), 32'h1);
        checkOutput("single_wd",  32'(bus.write_data),   32'hA123);
        checkOutput("single_err", 32'(bus.sel_err),      32'h0);

        // Far transfer alone, which also brings the pointer back to writeback.
        applyStimulus(3'b010, 3'd0, 16'h0, 3'd3, 16'h1234, 3'd0, 16'h0);
        #1;
        checkOutput("far_ready", 32'(bus.req_ready), 32'h2);
        nextCycle();
        idle();
        checkOutput("far_we", 32'(bus.write_enable), 32'h1);
        checkOutput("far_ws", 32'(bus.write_select), 32'h3);
        checkOutput("far_wd", 32'(bus.write_data),   32'h1234);
        nextCycle();
        checkOutput("idle_we", 32'(bus.write_enable), 32'h0);

        // Contention with an exception inserted in cycle 2.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(c_valid[i], 3'd0, 16'h1111, 3'd5, 16'h2222, 3'd4, 16'h3333);
            #1;
            checkOutput($sformatf("cont_ready%0d", i), 32'(bus.req_ready), 32'(c_ready[i]));
            nextCycle();
            checkOutput($sformatf("cont_ws%0d", i), 32'(bus.write_select), 32'(c_sel[i]));
            checkOutput($sformatf("cont_wd%0d", i), 32'(bus.write_data),   32'(c_data[i]));
        end
        idle();
        checkOutput("cont_busy", 32'(bus.seg_busy), 32'h0);

        // Scoreboard: fill DS, saturate, reserve-with-drain, then drain.
        for (int i = 0; i < 3; i++) begin
            bus.rsv_valid = 1'b1;
            bus.rsv_sel   = 3'd3;
            #1;
            checkOutput($sformatf("sb_rsv_ready%0d", i), 32'(bus.rsv_ready), 32'h1);
            nextCycle();
            checkOutput($sformatf("sb_busy%0d", i), 32'(bus.seg_busy), 32'h08);
        end
        #1;
        checkOutput("sb_full_rsv", 32'(bus.rsv_ready), 32'h0);
        applyStimulus(3'b001, 3'd3, 16'hD5D5, 3'd0, 16'h0, 3'd0, 16'h0);
        #1;
        checkOutput("sb_same_rsv", 32'(bus.rsv_ready), 32'h1);
        checkOutput("sb_same_req", 32'(bus.req_ready), 32'h1);
        nextCycle();
        bus.req_valid = 3'b000;
        checkOutput("sb_same_we",   32'(bus.write_enable), 32'h1);
        checkOutput("sb_same_ws",   32'(bus.write_select), 32'h3);
        checkOutput("sb_same_busy", 32'(bus.seg_busy),     32'h08);
        #1;
        checkOutput("sb_still_full", 32'(bus.rsv_ready), 32'h0);
        bus.rsv_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b001, 3'd3, 16'h0D00, 3'd0, 16'h0, 3'd0, 16'h0);
            #1;
            checkOutput($sformatf("sb_wb_ready%0d", i), 32'(bus.req_ready), 32'h1);
            nextCycle();
            checkOutput($sformatf("sb_wb_busy%0d", i), 32'(bus.seg_busy),
                        (i == 2) ? 32'h00 : 32'h08);
        end
        idle();

        // Flush with SS count at 2.
        for (int i = 0; i < 2; i++) begin
            bus.rsv_valid = 1'b1;
            bus.rsv_sel   = 3'd2;
            #1;
            checkOutput($sformatf("fl_rsv%0d", i), 32'(bus.rsv_ready), 32'h1);
            nextCycle();
        end
        checkOutput("fl_busy_pre", 32'(bus.seg_busy), 32'h04);
        applyStimulus(3'b101, 3'd2, 16'h0BAD, 3'd0, 16'h0, 3'd1, 16'hE0E0);
        bus.rsv_valid = 1'b1;
        bus.rsv_sel   = 3'd2;
        bus.flush     = 1'b1;
        #1;
        checkOutput("fl_req_ready", 32'(bus.req_ready), 32'h4);
        checkOutput("fl_rsv_ready", 32'(bus.rsv_ready), 32'h0);
        nextCycle();
        idle();
        checkOutput("fl_busy", 32'(bus.seg_busy),     32'h00);
        checkOutput("fl_we",   32'(bus.write_enable), 32'h1);
        checkOutput("fl_ws",   32'(bus.write_select), 32'h1);
        checkOutput("fl_wd",   32'(bus.write_data),   32'hE0E0);

        // Illegal select with ES holding one pending write.
        bus.rsv_valid = 1'b1;
        bus.rsv_sel   = 3'd0;
        nextCycle();
        applyStimulus(3'b001, 3'd7, 16'hFFFF, 3'd0, 16'h0, 3'd0, 16'h0);
        bus.rsv_sel = 3'd6;
        #1;
        checkOutput("ill_ready",   32'(bus.req_ready), 32'h1);
        checkOutput("ill_rsv_sel", 32'(bus.rsv_ready), 32'h0);
        nextCycle();
        idle();
        checkOutput("ill_we",   32'(bus.write_enable), 32'h0);
        checkOutput("ill_err",  32'(bus.sel_err),      32'h1);
        checkOutput("ill_busy", 32'(bus.seg_busy),     32'h01);
        nextCycle();
        checkOutput("ill_err_clr", 32'(bus.sel_err),  32'h0);
        checkOutput("ill_busy2",   32'(bus.seg_busy), 32'h01);

        // Reset in the cycle after a writeback grant.
        applyStimulus(3'b001, 3'd2, 16'h5555, 3'd3, 16'h6666, 3'd0, 16'h0);
        #1;
        checkOutput("mid_ready", 32'(bus.req_ready), 32'h1);
        nextCycle();
        reset         = 1'b1;
        bus.req_valid = 3'b011;
        #1;
        checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        nextCycle();
        reset = 1'b0;
        checkOutput("mid_we",   32'(bus.write_enable), 32'h0);
        checkOutput("mid_ws",   32'(bus.write_select), 32'h0);
        checkOutput("mid_wd",   32'(bus.write_data),   32'h0);
        checkOutput("mid_err",  32'(bus.sel_err),      32'h0);
        checkOutput("mid_busy", 32'(bus.seg_busy),     32'h00);
        #1;
        checkOutput("mid_rr_ready", 32'(bus.req_ready), 32'h1);
        nextCycle();
        idle();
        checkOutput("mid_post_we", 32'(bus.write_enable), 32'h1);
        checkOutput("mid_post_ws", 32'(bus.write_select), 32'h2);
        checkOutput("mid_post_wd", 32'(bus.write_data),   32'h5555);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/segment_write_arbiter.md
# segment_write_arbiter

Shares the single write port of `segment_register_file` among three requesters: writeback, far control transfer, and the exception unit. It drives that port from registers. It also keeps a per-segment pending-write scoreboard so decode can stall on reads of a segment that still has a write in flight. It sits between writeback/branch/exception logic and `segment_register_file`.

## Interface
- `NREQ`, 3: number of requesters. Fixed at 3 in this revision.
- `CNT_W`, 2: width of each pending counter, so at most 3 writes outstanding per segment.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 3: per-requester write request. Bit 0 = writeback, 1 = far transfer, 2 = exception.
- `req_sel` in 3×3: segment select for each requester. ES=0, CS=1, SS=2, DS=3, FS=4, GS=5.
- `req_data` in 3×16: selector value for each requester.
- `req_ready` out 3: grant, asserted in the same cycle as the request (combinational from valid, priority and flush).
- `rsv_valid` in 1: decode reserves a future write to `rsv_sel`.
- `rsv_sel` in 3: segment to reserve.
- `rsv_ready` out 1: the reservation is accepted this cycle.
- `flush` in 1: pipeline flush. Clears the scoreboard.
- `write_select` out 3: drives the register file write port.
- `write_data` out 16: drives the register file write port.
- `write_enable` out 1: drives the register file write port.
- `seg_busy` out 6: bit n is set while pending count[n] is nonzero. Registered.
- `sel_err` out 1: one-cycle pulse when a granted request has select 6 or 7.

## Operation
- Arbitration is round-robin over the valid requesters, starting at `rr_ptr`. Exception (bit 2) always wins when valid; it preempts the rotation but does not advance `rr_ptr`.
- At most one grant per cycle. A grant is a handshake when `req_valid[i] && req_ready[i]`.
- After a round-robin grant to i, `rr_ptr` becomes (i+1) mod 2 over requesters 0 and 1.
- While `flush` is high, `req_ready[0]` is 0, so writeback is squashed. Requesters 1 and 2 are still granted.
- On a grant with a legal select, the next cycle has:
  - `write_enable`=1;
  - `write_select` and `write_data` registered from the granted request.
- On a grant with select ≥6:
  - the request is consumed;
  - `write_enable` stays 0 next cycle;
  - `sel_err` pulses next cycle.
- Scoreboard: one `cnt[n]` per segment, `CNT_W` bits each.
  - An accepted reservation increments `cnt[rsv_sel]`.
  - A legal writeback (requester 0) grant decrements `cnt[req_sel[0]]` if it is nonzero.
  - Requesters 1 and 2 never touch the counters.
- `rsv_ready` = !flush && rsv_sel<6 && (cnt[rsv_sel] != max || a decrement of the same segment happens this cycle).
- Reserve and decrement of the same segment in the same cycle leaves the count unchanged.
- A decrement when the count is 0 is ignored; the count does not wrap.
- `flush` sets every count to 0 next cycle. This overrides any reservation or decrement in the same cycle.
- `seg_busy` = registered (cnt != 0), taken after the update.

## Timing
- Grant is combinational in cycle t.
- The write port is driven in t+1, and the register file captures the value at the t+2 edge.
- Sustained throughput is one write per cycle.
- `seg_busy` reflects a reservation or write accepted in t from cycle t+1.
- Reset values: `write_enable`=0, `write_select`=0, `write_data`=0, `sel_err`=0, `seg_busy`=0, all counts 0, `rr_ptr`=0.
- Reset during traffic discards any staged write, so no write pulse appears in the cycle after reset.
- `req_ready` is 0 while `reset` is high.
- `rsv_ready` is 0 while `reset` is high.

## Structure
- Shared package `seg_pkg`:
  - segment encoding constants `SEG_ES..SEG_GS`;
  - `SEG_NUM`=6;
  - requester index constants `REQ_WB`, `REQ_FAR`, `REQ_EXC`.
  - `segment_register_file` uses the same package for its select decoding.
- One sub-module, `seg_pending_counter`: a single saturating up/down counter with inc, dec and clear inputs and a busy output, instantiated 6 times.
- The arbiter and output staging live in the top level.

## Test plan
- **Single request.** Reset, then `req_valid`=001, sel=1, data=16'hA123 → `req_ready`=001. Next cycle: `write_enable`=1, `write_select`=1, `write_data`=A123. The CS output of the register file reads A123 one cycle later.
- **Contention.** Requesters 0 and 1 valid together for 4 cycles → grants alternate 0,1,0,1. Adding requester 2 in cycle 2 → requester 2 is granted that cycle and the alternation resumes at the same position.
- **Scoreboard.** Reserve DS 3 times → `seg_busy[3]`=1 and a 4th reservation gets `rsv_ready`=0. Reserve and writeback-grant DS in the same cycle → count stays 3. Three more writebacks → `seg_busy[3]`=0.
- **Flush.** With count[SS]=2, assert `flush` together with writeback, exception and reserve requests → `req_ready`=100 and `rsv_ready`=0. Next cycle: all counts 0, and the exception write appears on the port.
- **Illegal select.** Writeback with sel=7, data=FFFF → request granted; next cycle `write_enable`=0 and `sel_err`=1 for exactly one cycle; the count for sel is unchanged.
- **Reset mid-stream.** Assert `reset` in the cycle after a grant → no write pulse. Afterwards all outputs read 0 and `rr_ptr` favours requester 0.
